// File: rtl/ps2_mouse_pkg.sv
// Shared constants, state encoding and command lookup for the PS/2 mouse
// initialisation sequencer.
package ps2_mouse_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Mouse-to-host response bytes
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [2:0] {
        SEND,
        WAIT_TX,
        WAIT_ACK,
        WAIT_BAT,
        WAIT_ID,
        ERROR,
        STREAM,
        FAIL
    } state_t;

    // Byte transmitted at each step of the init sequence; step 2 carries the
    // argument of the preceding Set Sample Rate command.
    function automatic logic [7:0] step_cmd(input logic [1:0] step, input logic [7:0] rate);
        case (step)
            2'd0:    return CMD_RESET;
            2'd1:    return CMD_SET_RATE;
            2'd2:    return rate;
            default: return CMD_ENABLE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up / recovery sequencer. Sends Reset, Set Sample Rate,
// the rate value and Enable Data Reporting, checks each response, retries the
// whole sequence on error or timeout, and opens the packet path only once the
// mouse is streaming.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter int unsigned ACK_TIMEOUT = 2_000_000,
    parameter int unsigned BAT_TIMEOUT = 100_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    output logic [7:0] tx_byte,
    output logic       tx_req,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       stream_en,
    output logic       init_busy,
    output logic       init_fail,
    output logic [1:0] retry_cnt
);

    // The timer is sized for the longest wait (BAT) and shared by all states.
    localparam int unsigned TIMER_W = $clog2(BAT_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] ACK_LIMIT   = TIMER_W'(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] BAT_LIMIT   = TIMER_W'(BAT_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
    localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRY);

    state_t             state;
    logic [1:0]         step;
    logic [TIMER_W-1:0] timer;
    logic               resend_seen;   // one 0xFE already honoured for this byte

    // The command byte is a pure decode of the step register, so it stays
    // stable for the whole transmit/acknowledge handshake.
    assign tx_byte = step_cmd(step, SAMPLE_RATE);

    // Sequencer FSM with registered outputs and an inline saturating timer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only in clocked logic, so every branch
        // below sees the pre-edge values of state, step and timer.
        if (rst || reinit) begin
            state       <= SEND;
            step        <= 2'd0;
            retry_cnt   <= 2'd0;
            timer       <= '0;
            resend_seen <= 1'b0;
            tx_req      <= 1'b0;
            stream_en   <= 1'b0;
            init_busy   <= 1'b1;
            init_fail   <= 1'b0;
        end else begin
            tx_req <= 1'b0;
            if (timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end

            unique case (state)
                SEND: begin
                    tx_req <= 1'b1;
                    state  <= WAIT_TX;
                    timer  <= '0;
                end

                WAIT_TX: begin
                    // Received bytes are ignored here; an abort beats completion.
                    if (tx_err) begin
                        state <= ERROR;
                        timer <= '0;
                    end else if (tx_done) begin
                        state <= WAIT_ACK;
                        timer <= '0;
                    end else if (timer >= ACK_LIMIT) begin
                        state <= ERROR;
                        timer <= '0;
                    end
                end

                WAIT_ACK: begin
                    // A byte arriving on the timeout cycle still counts.
                    if (rx_valid) begin
                        timer <= '0;
                        if (rx_byte == RSP_ACK) begin
                            resend_seen <= 1'b0;
                            case (step)
                                2'd0: state <= WAIT_BAT;
                                2'd3: begin
                                    state     <= STREAM;
                                    stream_en <= 1'b1;
                                    init_busy <= 1'b0;
                                end
                                default: begin
                                    step  <= step + 1'b1;
                                    state <= SEND;
                                end
                            endcase
                        end else if (rx_byte == RSP_RESEND && !resend_seen) begin
                            resend_seen <= 1'b1;
                            state       <= SEND;
                        end else begin
                            state <= ERROR;
                        end
                    end else if (timer >= ACK_LIMIT) begin
                        state <= ERROR;
                        timer <= '0;
                    end
                end

                WAIT_BAT: begin
                    if (rx_valid) begin
                        timer <= '0;
                        state <= (rx_byte == RSP_BAT_OK) ? WAIT_ID : ERROR;
                    end else if (timer >= BAT_LIMIT) begin
                        state <= ERROR;
                        timer <= '0;
                    end
                end

                WAIT_ID: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (rx_byte == RSP_ID) begin
                            step  <= 2'd1;
                            state <= SEND;
                        end else begin
                            state <= ERROR;
                        end
                    end else if (timer >= BAT_LIMIT) begin
                        state <= ERROR;
                        timer <= '0;
                    end
                end

                ERROR: begin
                    timer       <= '0;
                    resend_seen <= 1'b0;
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        step      <= 2'd0;
                        state     <= SEND;
                    end else begin
                        state     <= FAIL;
                        init_fail <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end

                // Terminal states: only reinit or rst leave them.
                STREAM: ;
                FAIL: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Self-checking bench for ps2_mouse_init_ctrl. A reference model expands a
// list of per-transaction mouse behaviours into the expected command/retry
// sequence and final outcome; a monitor process compares DUT activity
// against those queues while the stimulus process plays transceiver+mouse.
module tb_ps2_mouse_init_ctrl;

    localparam logic [7:0] RATE   = 8'd100;
    localparam int         ACK_TO = 50;
    localparam int         BAT_TO = 200;
    localparam int         MAXR   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_req;
    logic       stream_en;
    logic       init_busy;
    logic       init_fail;
    logic [1:0] retry_cnt;

    ps2_mouse_init_ctrl #(
        .SAMPLE_RATE (RATE),
        .ACK_TIMEOUT (ACK_TO),
        .BAT_TIMEOUT (BAT_TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reinit    (reinit),
        .tx_byte   (tx_byte),
        .tx_req    (tx_req),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .stream_en (stream_en),
        .init_busy (init_busy),
        .init_fail (init_fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // How the simulated transceiver/mouse reacts to one transmitted byte.
    typedef enum int {
        F_OK, F_STRAY, F_RESEND, F_TXERR, F_BOTH, F_NOTX, F_NOACK,
        F_BADACK, F_BATERR, F_NOBAT, F_BADID, F_RST
    } fault_e;

    typedef struct { fault_e f; logic [7:0] cmd; } txn_t;
    typedef struct { logic [7:0] cmd; logic [1:0] retry; } exp_tx_t;
    typedef struct { bit stream; logic [1:0] retry; } exp_end_t;

    txn_t     txn_q[$];
    exp_tx_t  exp_q[$];
    exp_end_t end_q[$];
    fault_e   dir_q[$];
    bit       expect_end;
    int       checks = 0;
    int       errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cmd_of(input int s);
        logic [7:0] tbl [4];
        tbl = '{8'hFF, 8'hF3, RATE, 8'hF4};
        return tbl[s];
    endfunction

    function automatic fault_e rand_fault();
        fault_e f;
        if ($urandom_range(0, 99) < 60) return F_OK;
        case ($urandom_range(0, 10))
            0:       f = F_STRAY;
            1, 2:    f = F_RESEND;
            3:       f = F_TXERR;
            4:       f = F_BOTH;
            5:       f = F_NOTX;
            6:       f = F_NOACK;
            7:       f = F_BADACK;
            8:       f = F_BATERR;
            9:       f = F_NOBAT;
            default: f = F_BADID;
        endcase
        return f;
    endfunction

    // Reference model: walk the init sequence at the level of "which byte is
    // sent with which retry count", applying the mouse behaviour per byte.
    task automatic build_scenario(input bit rnd);
        int      s = 0;
        int      r = 0;
        bit      last_resend = 0;
        bit      done = 0;
        bit      err;
        fault_e  f;
        txn_t    t;
        exp_tx_t e;
        exp_end_t x;
        expect_end = 0;
        while (!done) begin
            if (dir_q.size() > 0) f = dir_q.pop_front();
            else if (rnd)         f = rand_fault();
            else                  f = F_OK;
            if (s != 0 && f inside {F_BATERR, F_NOBAT, F_BADID, F_RST}) f = F_OK;
            t.f = f; t.cmd = cmd_of(s);
            txn_q.push_back(t);
            e.cmd = cmd_of(s); e.retry = 2'(r);
            exp_q.push_back(e);
            err = 0;
            case (f)
                F_OK, F_STRAY: begin
                    last_resend = 0;
                    s++;
                    if (s == 4) begin
                        x.stream = 1'b1; x.retry = 2'(r);
                        end_q.push_back(x);
                        expect_end = 1;
                        done = 1;
                    end
                end
                F_RESEND: if (last_resend) err = 1; else last_resend = 1;
                F_RST:    done = 1;
                default:  err = 1;
            endcase
            if (err) begin
                last_resend = 0;
                if (r < MAXR) begin
                    r++;
                    s = 0;
                end else begin
                    x.stream = 1'b0; x.retry = 2'(r);
                    end_q.push_back(x);
                    expect_end = 1;
                    done = 1;
                end
            end
        end
    endtask

    task automatic pulse_tx(input bit done, input bit err);
        tx_done = done; tx_err = err;
        @(negedge clk);
        tx_done = 1'b0; tx_err = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_byte = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_req"},    tx_req,    0);
        check({tag, "_tx_byte"},   tx_byte,   8'hFF);
        check({tag, "_stream_en"}, stream_en, 0);
        check({tag, "_init_busy"}, init_busy, 1);
        check({tag, "_init_fail"}, init_fail, 0);
        check({tag, "_retry_cnt"}, retry_cnt, 0);
    endtask

    // Mouse behaviour after the ACK to the Reset command.
    task automatic respond_bat(input fault_e f);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        case (f)
            F_BATERR: pulse_rx(8'hFC);
            F_NOBAT:  ;
            F_RST: begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                check_reset_outputs("rst_in_bat");
                rst = 1'b0;
            end
            F_BADID: begin
                pulse_rx(8'hAA);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                pulse_rx(8'($urandom_range(1, 255)));
            end
            default: begin
                pulse_rx(8'hAA);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                pulse_rx(8'h00);
            end
        endcase
    endtask

    task automatic respond(input txn_t t);
        logic [7:0] b;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        case (t.f)
            F_NOTX:  ;
            F_TXERR: pulse_tx(1'b0, 1'b1);
            F_BOTH:  pulse_tx(1'b1, 1'b1);
            default: begin
                if (t.f == F_STRAY) pulse_rx(8'hFA);
                pulse_tx(1'b1, 1'b0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                case (t.f)
                    F_NOACK:  ;
                    F_RESEND: pulse_rx(8'hFE);
                    F_BADACK: begin
                        do b = 8'($urandom); while (b == 8'hFA || b == 8'hFE);
                        pulse_rx(b);
                    end
                    default: begin
                        if (t.cmd == 8'hF4) begin
                            check("stream_before_last_ack", stream_en, 0);
                            pulse_rx(8'hFA);
                            check("stream_one_cycle_after_ack", stream_en, 1);
                        end else begin
                            pulse_rx(8'hFA);
                        end
                        if (t.cmd == 8'hFF) respond_bat(t.f);
                    end
                endcase
            end
        endcase
    endtask

    task automatic wait_txreq(input int budget, input bit now, output bit ok);
        ok = now && (tx_req === 1'b1);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (tx_req === 1'b1);
        end
    endtask

    task automatic run_scenario(input int first_budget, input bit first_now);
        bit   ok;
        txn_t t;
        int   n = 0;
        while (txn_q.size() > 0) begin
            t = txn_q.pop_front();
            wait_txreq((n == 0) ? first_budget : 1000, (n == 0) ? first_now : 1'b0, ok);
            if (!ok) begin
                check("tx_req_arrived", tx_req, 1);
                txn_q.delete(); exp_q.delete(); end_q.delete();
                return;
            end
            respond(t);
            n++;
        end
        if (expect_end) begin
            for (int i = 0; i < 1000 && !(stream_en === 1'b1 || init_fail === 1'b1); i++)
                @(negedge clk);
            @(negedge clk);
            check("outcome_reached", stream_en | init_fail, 1);
            check("outcome_queue_drained", end_q.size(), 0);
        end
        check("tx_queue_drained", exp_q.size(), 0);
        exp_q.delete(); end_q.delete();
    endtask

    task automatic reinit_and_run(input bit rnd);
        build_scenario(rnd);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        check("reinit_stream_en", stream_en, 0);
        check("reinit_init_fail", init_fail, 0);
        check("reinit_init_busy", init_busy, 1);
        check("reinit_retry_cnt", retry_cnt, 0);
        check("reinit_tx_byte",   tx_byte,   8'hFF);
        run_scenario(2, 1'b1);
    endtask

    // Monitor: compares every tx_req and every outcome edge to the model.
    logic prev_req = 1'b0, prev_stream = 1'b0, prev_fail = 1'b0;
    always @(negedge clk) begin
        exp_tx_t  e;
        exp_end_t x;
        if (tx_req === 1'b1) begin
            check("tx_req_single_cycle", prev_req, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_tx_req", tx_req, 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", tx_byte, e.cmd);
                check("retry_cnt_at_tx_req", retry_cnt, e.retry);
            end
        end
        if ((stream_en === 1'b1 && prev_stream !== 1'b1) ||
            (init_fail === 1'b1 && prev_fail !== 1'b1)) begin
            if (end_q.size() == 0) begin
                check("unexpected_outcome", stream_en | init_fail, 0);
            end else begin
                x = end_q.pop_front();
                check("outcome_stream_en", stream_en, x.stream);
                check("outcome_init_fail", init_fail, !x.stream);
                check("outcome_retry_cnt", retry_cnt, x.retry);
                check("outcome_init_busy", init_busy, 0);
            end
        end
        prev_req    <= tx_req;
        prev_stream <= stream_en;
        prev_fail   <= init_fail;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Clean init
        build_scenario(1'b0);
        rst = 1'b0;
        run_scenario(1000, 1'b0);

        // Single resend of F3, then a double resend that forces a retry
        dir_q = {F_OK, F_RESEND};
        reinit_and_run(1'b0);
        dir_q = {F_OK, F_RESEND, F_RESEND};
        reinit_and_run(1'b0);

        // Silence on every attempt ends in FAIL after four attempts
        dir_q = {F_NOACK, F_NOTX, F_NOACK, F_NOTX};
        reinit_and_run(1'b0);

        // BAT error then recovery (reinit out of FAIL)
        dir_q = {F_BATERR};
        reinit_and_run(1'b0);

        // tx_err+tx_done together, stray byte during transmit
        dir_q = {F_BOTH, F_STRAY};
        reinit_and_run(1'b0);

        // Mixed failures using every retry, still reaching STREAM
        dir_q = {F_TXERR, F_OK, F_BADACK, F_BADID};
        reinit_and_run(1'b0);

        // Synchronous reset while waiting for the BAT byte
        dir_q = {F_RST};
        reinit_and_run(1'b0);
        build_scenario(1'b0);
        run_scenario(1000, 1'b0);

        // Randomised mouse behaviour
        for (int k = 0; k < 20; k++) reinit_and_run(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
Power-up and recovery sequencer for the PS/2 mouse link, placed between the byte-level PS/2 transceiver and the mouse packet decoder.
- Issues the init command sequence: Reset, Set Sample Rate, rate value, Enable Data Reporting.
- Checks every response byte and retries on error or timeout.
- Opens the packet path (stream_en) only once the mouse is streaming, so the cursor and click logic never sees init handshake bytes.

Parameters:
SAMPLE_RATE, 8'd100, argument byte sent after the 0xF3 command
ACK_TIMEOUT, 2_000_000, clk cycles to wait for a tx_done or an ACK byte
BAT_TIMEOUT, 100_000_000, clk cycles to wait for each of the 0xAA and 0x00 bytes after reset
MAX_RETRY, 3, full-sequence retries allowed before declaring failure

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous active-high reset
reinit  in  1  one-cycle pulse; restarts the sequence from step 0
tx_byte  out  8  command byte to the transceiver; held stable until tx_done or tx_err
tx_req  out  1  one-cycle pulse requesting transmission of tx_byte
tx_done  in  1  transceiver finished sending the byte
tx_err  in  1  transceiver aborted (no device clock, or no line ACK)
rx_byte  in  8  received byte
rx_valid  in  1  one-cycle strobe qualifying rx_byte
stream_en  out  1  high only in STREAM; gates rx bytes to the packet decoder
init_busy  out  1  high in every state except STREAM and FAIL
init_fail  out  1  high in FAIL
retry_cnt  out  2  retries consumed in the current attempt

Behaviour:
- Reset: on a clk edge with rst=1, the block enters SEND with step=0, retry_cnt=0, timer=0. Outputs during reset: tx_req=0, tx_byte=0xFF, stream_en=0, init_busy=1, init_fail=0.
- Step ROM: step 0=0xFF, 1=0xF3, 2=SAMPLE_RATE, 3=0xF4. tx_byte always reflects step.
- SEND:
  - pulse tx_req for exactly 1 cycle;
  - next state WAIT_TX;
  - timer cleared.
- WAIT_TX:
  - tx_err → ERROR;
  - tx_done → WAIT_ACK, timer cleared;
  - if both in the same cycle, tx_err wins;
  - timer reaching ACK_TIMEOUT → ERROR.
- WAIT_ACK (rx_valid is acted on only in this state, WAIT_BAT and WAIT_ID; any other rx byte outside STREAM is dropped):
  - 0xFA, step 0 → WAIT_BAT;
  - 0xFA, step 1 or 2 → step+1, SEND;
  - 0xFA, step 3 → STREAM;
  - 0xFE → SEND with the same step; does not touch retry_cnt; at most 1 consecutive resend, a second 0xFE → ERROR;
  - any other byte, or timer reaching ACK_TIMEOUT → ERROR.
- WAIT_BAT:
  - 0xAA → WAIT_ID, timer cleared;
  - 0xFC, other byte, or BAT_TIMEOUT → ERROR.
- WAIT_ID:
  - 0x00 → step=1, SEND;
  - other byte or BAT_TIMEOUT → ERROR.
- ERROR (1 cycle):
  - retry_cnt<MAX_RETRY → retry_cnt+1, step=0, SEND;
  - otherwise → FAIL.
- STREAM:
  - stream_en=1, init_busy=0;
  - terminal until reinit or rst;
  - rx bytes are not inspected.
- FAIL:
  - init_fail=1, stream_en=0, init_busy=0;
  - terminal until reinit or rst.
- reinit, in any state: next cycle SEND, step=0, retry_cnt=0, timer=0, resend flag cleared, stream_en drops the same edge.
- Priority: rst > reinit > rx_valid > timeout. A byte arriving on the timeout cycle is accepted.
- Timer:
  - width $clog2(BAT_TIMEOUT+1);
  - saturates, never wraps;
  - cleared on every state entry;
  - compared with >= against the state's limit.
- Latency: tx_req asserts 1 cycle after reset release or reinit. stream_en asserts the cycle after the final 0xFA strobe.

Decomposition:
- Package ps2_mouse_pkg holds:
  - byte constants: CMD_RESET 0xFF, CMD_SET_RATE 0xF3, CMD_ENABLE 0xF4, RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_ERR 0xFC, RSP_BAT_OK 0xAA, RSP_ID 0x00;
  - state encoding SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, ERROR, STREAM, FAIL;
  - step-to-command function.
- Single module; no sub-module. The timer is a few lines inline.

Test Plan (ACK_TIMEOUT=50, BAT_TIMEOUT=200, MAX_RETRY=3):
1. Normal init. Model answers tx_done, FA, AA, 00, FA, FA, FA → tx_byte sequence FF, F3, 64, F4; 4 tx_req pulses; stream_en=1 one cycle after the last FA; retry_cnt=0.
2. Resend. 0xFE after F3, then FA → F3 re-sent once; retry_cnt stays 0; reaches STREAM. Two consecutive FE → ERROR, retry_cnt=1, restart at FF.
3. Timeouts. No response to any byte → 4 attempts (retry_cnt 0→3), then FAIL with init_fail=1. Check that no FAIL is declared before 4 timeouts have elapsed.
4. BAT fail. 0xFC instead of 0xAA → ERROR, retry_cnt=1; next attempt passes → STREAM.
5. tx_err and tx_done in the same cycle → treated as error, retry_cnt increments. An rx byte during WAIT_TX is ignored.
6. reinit pulse while in STREAM and while in FAIL → next cycle tx_req with tx_byte=0xFF, stream_en=0, init_fail=0, retry_cnt=0. rst asserted mid-WAIT_BAT gives the same result.
